// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data RAM with programmable wait states,
// byte-lane writes, registered read data and a one-cycle ready/err response.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int WAIT_CYCLES = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     we_q, we_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           oor_q, oor_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           ready_q, ready_d;
    logic           err_q, err_d;
    logic           to_resp;
    logic           in_oor;
    logic           unused_addr;
    logic [31:0]    mem [DEPTH];

    assign in_oor = addr[31:AW+2] != '0;
    assign unused_addr = ^addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        to_resp = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                we_d    = we;
                idx_d   = addr[AW+1:2];
                oor_d   = in_oor;
                wdata_d = wdata;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
                to_resp = WAIT_CYCLES == 0;
            end
            WAIT: begin
                cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    to_resp = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The _d copies hold the transaction's values whether just latched or held.
        if (to_resp) begin
            ready_d = 1'b1;
            err_d   = oor_d;
            if (we_d == 4'd0) rdata_d = oor_d ? 32'd0 : mem[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RESP && !oor_q)
            for (int b = 0; b < 4; b++)
                if (we_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors on a 2-wait-state instance plus a
// zero-wait-state instance, with hand sequences for reset abort and req drop.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, req0 = 1'b0;
    logic [3:0]  we = '0, we0 = '0;
    logic [31:0] addr = '0, addr0 = '0, wdata = '0, wdata0 = '0;
    logic [31:0] rdata, rdata0;
    logic        ready, ready0, busy, busy0, err, err0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;
    vec_t v[15];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input bit d, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] wd, input bit drop,
                       input logic [31:0] exp_rd, input logic exp_err, input string name);
        int k = 0;
        bit got = 0;
        bit busy_ok = 1;
        @(negedge clk);
        if (d) begin req0 = 1; we0 = w; addr0 = a; wdata0 = wd; end
        else begin req = 1; we = w; addr = a; wdata = wd; end
        @(posedge clk);
        #1;
        if (drop) begin
            req = 0; req0 = 0;
            we = 4'hF; addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD;
        end
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if ((d ? busy0 : busy) !== 1'b1) busy_ok = 0;
            if ((d ? ready0 : ready) === 1'b1) got = 1;
        end
        req = 0; req0 = 0;
        chk({name, " latency"}, k, d ? 32'd1 : 32'd3);
        chk({name, " rdata"}, d ? rdata0 : rdata, exp_rd);
        chk({name, " err"}, {31'd0, d ? err0 : err}, {31'd0, exp_err});
        chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        int cnt;
        v[0]  = '{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        v[1]  = '{4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        v[2]  = '{4'hF, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
        v[3]  = '{4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'hDEAD_BEEF, 1'b0};
        v[4]  = '{4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
        v[5]  = '{4'hF, 32'h0000_0000, 32'h1234_5678, 32'h11BB_33DD, 1'b0};
        v[6]  = '{4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h11BB_33DD, 1'b1};
        v[7]  = '{4'h0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
        v[8]  = '{4'h0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
        v[9]  = '{4'hF, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678, 1'b0};
        v[10] = '{4'h9, 32'h0000_0040, 32'hAABB_CCDD, 32'h1234_5678, 1'b0};
        v[11] = '{4'h0, 32'h0000_0040, 32'h0,         32'hAA00_00DD, 1'b0};
        v[12] = '{4'h0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
        v[13] = '{4'h0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
        v[14] = '{4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle ready/busy/err", {29'd0, ready, busy, err}, 32'd0);
            chk("idle rdata", rdata, 32'd0);
        end

        for (int i = 0; i < 15; i++)
            txn(0, v[i].we, v[i].addr, v[i].wdata, 0, v[i].rd, v[i].err, $sformatf("vec%0d", i));

        txn(0, 4'h0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, "req drop");

        txn(0, 4'hF, 32'h0000_0030, 32'h55AA_55AA, 0, 32'hDEAD_BEEF, 1'b0, "pre-abort write");
        @(negedge clk);
        req = 1; we = 4'hF; addr = 32'h0000_0030; wdata = 32'h0000_0000;
        @(posedge clk);
        #1 req = 0;
        @(negedge clk);
        chk("abort busy before reset", {31'd0, busy}, 32'd1);
        rst = 0;
        #1;
        chk("abort busy/ready after reset", {30'd0, busy, ready}, 32'd0);
        chk("abort rdata after reset", rdata, 32'd0);
        @(negedge clk);
        rst = 1;
        txn(0, 4'h0, 32'h0000_0030, 32'h0, 0, 32'h55AA_55AA, 1'b0, "post-abort read");

        txn(1, 4'hF, 32'h0000_0008, 32'hCAFE_F00D, 0, 32'h0, 1'b0, "w0 write");
        txn(1, 4'h0, 32'h0000_0008, 32'h0, 0, 32'hCAFE_F00D, 1'b0, "w0 read");
        @(negedge clk);
        req0 = 1; we0 = 4'h0; addr0 = 32'h0000_0008;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready0 === 1'b1) begin
                cnt++;
                chk("w0 b2b rdata", rdata0, 32'hCAFE_F00D);
            end
        end
        req0 = 0;
        chk("w0 b2b count", cnt, 32'd4);
        txn(1, 4'h0, 32'h0000_0400, 32'h0, 0, 32'h0, 1'b1, "w0 oor read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
